// File: rtl/parking_gate_if.sv
// rtl/parking_gate_if.sv - sensor, full and pulse signals between the gate controller and its environment
interface parking_gate_if;
    logic sensor_a;
    logic sensor_b;
    logic full;
    logic inc;
    logic dec;
    logic gate_open;
    logic fault;

    modport master (
        output sensor_a,
        output sensor_b,
        output full,
        input  inc,
        input  dec,
        input  gate_open,
        input  fault
    );

    modport slave (
        input  sensor_a,
        input  sensor_b,
        input  full,
        output inc,
        output dec,
        output gate_open,
        output fault
    );
endinterface

// File: rtl/parking_gate_fsm.sv
// rtl/parking_gate_fsm.sv - debounced two-beam direction detector driving inc/dec pulses and the entry barrier
module parking_gate_fsm #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic          clk,
    input  logic          reset,
    parking_gate_if.slave gate
);

    localparam logic [7:0]  DEB_LIMIT = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_IN1    = 4'd1,
        S_IN2    = 4'd2,
        S_IN3    = 4'd3,
        S_OUT1   = 4'd4,
        S_OUT2   = 4'd5,
        S_OUT3   = 4'd6,
        S_REJECT = 4'd7,
        S_CLEAR  = 4'd8
    } state_t;

    // Bit 1 carries the outer beam (a), bit 0 the inner beam (b).
    logic [1:0]  raw;
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  deb;
    logic [7:0]  cnt [2];

    state_t      state;
    state_t      next_state;
    logic [15:0] timer;
    logic        in_passage;
    logic        timeout;

    logic        inc_d;
    logic        dec_d;
    logic        fault_d;
    logic        gate_d;

    logic        inc_q;
    logic        dec_q;
    logic        fault_q;
    logic        gate_q;

    assign raw = {gate.sensor_a, gate.sensor_b};

    assign gate.inc       = inc_q;
    assign gate.dec       = dec_q;
    assign gate.fault     = fault_q;
    assign gate.gate_open = gate_q;

    // Two-flop synchronizer for both raw beam inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-beam debouncer: a new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb    <= 2'b00;
            cnt[0] <= 8'd0;
            cnt[1] <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= 8'd0;
                end else if (cnt[i] + 8'd1 == DEB_LIMIT) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= 8'd0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    assign in_passage = (state == S_IN1)  || (state == S_IN2)  || (state == S_IN3) ||
                        (state == S_OUT1) || (state == S_OUT2) || (state == S_OUT3);

    // Next-state decision; a stalled passage is abandoned before any sensor transition is considered.
    always_comb begin
        next_state = state;
        timeout    = in_passage && (timer == TO_LAST);
        if (timeout) begin
            next_state = S_CLEAR;
        end else begin
            case (state)
                S_IDLE: begin
                    case (deb)
                        2'b10:   next_state = gate.full ? S_REJECT : S_IN1;
                        2'b01:   next_state = S_OUT1;
                        2'b11:   next_state = S_CLEAR;
                        default: next_state = S_IDLE;
                    endcase
                end
                S_IN1: begin
                    case (deb)
                        2'b11:   next_state = S_IN2;
                        2'b00:   next_state = S_IDLE;
                        2'b01:   next_state = S_CLEAR;
                        default: next_state = S_IN1;
                    endcase
                end
                S_IN2: begin
                    case (deb)
                        2'b01:   next_state = S_IN3;
                        2'b10:   next_state = S_IN1;
                        2'b00:   next_state = S_CLEAR;
                        default: next_state = S_IN2;
                    endcase
                end
                S_IN3: begin
                    case (deb)
                        2'b00:   next_state = S_IDLE;
                        2'b11:   next_state = S_IN2;
                        2'b10:   next_state = S_CLEAR;
                        default: next_state = S_IN3;
                    endcase
                end
                S_OUT1: begin
                    case (deb)
                        2'b11:   next_state = S_OUT2;
                        2'b00:   next_state = S_IDLE;
                        2'b10:   next_state = S_CLEAR;
                        default: next_state = S_OUT1;
                    endcase
                end
                S_OUT2: begin
                    case (deb)
                        2'b10:   next_state = S_OUT3;
                        2'b01:   next_state = S_OUT1;
                        2'b00:   next_state = S_CLEAR;
                        default: next_state = S_OUT2;
                    endcase
                end
                S_OUT3: begin
                    case (deb)
                        2'b00:   next_state = S_IDLE;
                        2'b11:   next_state = S_OUT2;
                        2'b01:   next_state = S_CLEAR;
                        default: next_state = S_OUT3;
                    endcase
                end
                S_REJECT: begin
                    if (deb == 2'b00) next_state = S_IDLE;
                end
                S_CLEAR: begin
                    if (deb == 2'b00) next_state = S_IDLE;
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Output decode from the transition being taken; results are registered alongside the state.
    always_comb begin
        inc_d   = (state == S_IN3)  && (next_state == S_IDLE);
        dec_d   = (state == S_OUT3) && (next_state == S_IDLE);
        fault_d = (next_state == S_CLEAR) && (state != S_CLEAR);
        gate_d  = (next_state == S_IN1) || (next_state == S_IN2) || (next_state == S_IN3);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Registered outputs so pulses and the barrier line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            fault_q <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            fault_q <= fault_d;
            gate_q  <= gate_d;
        end
    end

    // Passage timer: runs only while a car is mid-passage and restarts on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= 16'd0;
        end else if (!in_passage || (next_state != state)) begin
            timer <= 16'd0;
        end else begin
            timer <= timer + 16'd1;
        end
    end

endmodule

// File: tb/tb_parking_gate_fsm.sv
// tb/tb_parking_gate_fsm.sv - directed vector bench for parking_gate_fsm
module tb_parking_gate_fsm;

    logic clk;
    logic reset;

    parking_gate_if gif ();

    parking_gate_fsm #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gate (gif)
    );

    typedef struct {
        logic a;
        logic b;
        logic full;
        int   hold;
        int   exp_inc;
        int   exp_dec;
        int   exp_fault;
        logic exp_gate;
    } step_t;

    step_t steps[$];

    int n_checks;
    int n_fail;
    int inc_total;
    int dec_total;
    int fault_total;
    int excl_viol;
    logic prev_pulse;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and inc/dec exclusivity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (gif.inc) inc_total++;
        if (gif.dec) dec_total++;
        if (gif.fault) fault_total++;
        if ((gif.inc && gif.dec) || ((gif.inc || gif.dec) && prev_pulse)) excl_viol++;
        prev_pulse = gif.inc || gif.dec;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_step(input logic a, input logic b, input logic full, input int hold,
                            input int ei, input int ed, input int ef, input logic eg);
        step_t s;
        s = '{a, b, full, hold, ei, ed, ef, eg};
        steps.push_back(s);
    endtask

    task automatic drive(input logic a, input logic b);
        gif.sensor_a = a;
        gif.sensor_b = b;
    endtask

    // Cycles until the selected output is first seen high, or -1 when the bound expires.
    task automatic wait_out(input int sel, input int bound, output int lat);
        logic v;
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            tick(1);
            case (sel)
                0:       v = gif.gate_open;
                1:       v = gif.inc;
                2:       v = gif.dec;
                default: v = gif.fault;
            endcase
            if (v) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int i0, d0, f0, lat;
        logic gate_seen;

        n_checks   = 0;
        n_fail     = 0;
        inc_total  = 0;
        dec_total  = 0;
        fault_total = 0;
        excl_viol  = 0;
        prev_pulse = 1'b0;

        // Normal entry
        add_step(1, 0, 0, 20, 0, 0, 0, 1);
        add_step(1, 1, 0, 20, 0, 0, 0, 1);
        add_step(0, 1, 0, 20, 0, 0, 0, 1);
        add_step(0, 0, 0, 20, 1, 0, 0, 0);
        // Normal exit
        add_step(0, 1, 0, 20, 0, 0, 0, 0);
        add_step(1, 1, 0, 20, 0, 0, 0, 0);
        add_step(1, 0, 0, 20, 0, 0, 0, 0);
        add_step(0, 0, 0, 20, 0, 1, 0, 0);
        // Full lot: rejected
        add_step(1, 0, 1, 20, 0, 0, 0, 0);
        add_step(1, 1, 1, 20, 0, 0, 0, 0);
        add_step(0, 1, 1, 20, 0, 0, 0, 0);
        add_step(0, 0, 0, 20, 0, 0, 0, 0);
        // Full rising mid-passage: entry still completes
        add_step(1, 0, 0, 20, 0, 0, 0, 1);
        add_step(1, 1, 1, 20, 0, 0, 0, 1);
        add_step(0, 1, 1, 20, 0, 0, 0, 1);
        add_step(0, 0, 1, 20, 1, 0, 0, 0);
        // Back-off
        add_step(1, 0, 0, 20, 0, 0, 0, 1);
        add_step(0, 0, 0, 20, 0, 0, 0, 0);
        // Short glitch on b, then an entry still starts from IDLE
        add_step(0, 1, 0, 3,  0, 0, 0, 0);
        add_step(0, 0, 0, 20, 0, 0, 0, 0);
        add_step(1, 0, 0, 20, 0, 0, 0, 1);
        add_step(0, 0, 0, 20, 0, 0, 0, 0);
        // IN2 with both beams clearing at once
        add_step(1, 0, 0, 20, 0, 0, 0, 1);
        add_step(1, 1, 0, 20, 0, 0, 0, 1);
        add_step(0, 0, 0, 20, 0, 0, 1, 0);
        // Both beams together from IDLE
        add_step(1, 1, 0, 20, 0, 0, 1, 0);
        add_step(0, 0, 0, 20, 0, 0, 0, 0);

        reset = 1'b1;
        gif.full = 1'b0;
        drive(0, 0);
        tick(3);
        check("reset inc", int'(gif.inc), 0);
        check("reset dec", int'(gif.dec), 0);
        check("reset fault", int'(gif.fault), 0);
        check("reset gate_open", int'(gif.gate_open), 0);
        reset = 1'b0;
        tick(2);

        foreach (steps[s]) begin
            i0 = inc_total;
            d0 = dec_total;
            f0 = fault_total;
            drive(steps[s].a, steps[s].b);
            gif.full = steps[s].full;
            tick(steps[s].hold);
            check($sformatf("step%0d inc", s), inc_total - i0, steps[s].exp_inc);
            check($sformatf("step%0d dec", s), dec_total - d0, steps[s].exp_dec);
            check($sformatf("step%0d fault", s), fault_total - f0, steps[s].exp_fault);
            check($sformatf("step%0d gate_open", s), int'(gif.gate_open), int'(steps[s].exp_gate));
        end
        gif.full = 1'b0;

        // Raw-edge to output-edge latency on a full entry and exit
        drive(1, 0);
        wait_out(0, 20, lat);
        check("latency a rise to gate_open", lat, 7);
        tick(20);
        drive(1, 1);
        tick(20);
        drive(0, 1);
        tick(20);
        drive(0, 0);
        wait_out(1, 20, lat);
        check("latency b fall to inc", lat, 7);
        tick(1);
        check("gate_open low after inc", int'(gif.gate_open), 0);
        tick(20);
        drive(0, 1);
        tick(20);
        drive(1, 1);
        tick(20);
        drive(1, 0);
        tick(20);
        drive(0, 0);
        wait_out(2, 20, lat);
        check("latency a fall to dec", lat, 7);
        tick(20);

        // Parked in IN1 until the passage timer expires
        f0 = fault_total;
        drive(1, 0);
        wait_out(0, 20, lat);
        check("timeout gate_open rise", lat, 7);
        wait_out(3, 1100, lat);
        check("timeout cycles in IN1", lat, 1000);
        check("timeout gate_open low", int'(gif.gate_open), 0);
        gate_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick(1);
            if (gif.gate_open) gate_seen = 1'b1;
        end
        check("timeout stays in CLEAR", int'(gate_seen), 0);
        drive(0, 0);
        tick(20);
        check("timeout fault count", fault_total - f0, 1);

        // Reset while in IN3
        drive(1, 0);
        tick(20);
        drive(1, 1);
        tick(20);
        drive(0, 1);
        tick(20);
        check("IN3 before reset gate_open", int'(gif.gate_open), 1);
        i0 = inc_total;
        reset = 1'b1;
        drive(0, 0);
        #1;
        check("async reset gate_open", int'(gif.gate_open), 0);
        check("async reset inc", int'(gif.inc), 0);
        check("async reset fault", int'(gif.fault), 0);
        tick(2);
        reset = 1'b0;
        tick(30);
        check("no inc after reset", inc_total - i0, 0);
        check("gate_open after reset", int'(gif.gate_open), 0);

        check("inc/dec exclusivity", excl_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
